// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking occupancy controller.
package parking_pkg;

    typedef enum logic [1:0] {
        S_OPEN   = 2'd0,
        S_FULL   = 2'd1,
        S_CLOSED = 2'd2
    } lot_state_t;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] clamp_cap(
        input logic [31:0] v,
        input logic [31:0] cap
    );
        return (v > cap) ? cap : v;
    endfunction

endpackage

// File: rtl/lane_grant_arbiter.sv
// Grants up to 'limit' asserted requests, lowest index first.
module lane_grant_arbiter #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] limit,
    output logic [N-1:0] grant,
    output logic [N-1:0] reject
);

    // Counter wide enough for both the lane count and the limit.
    localparam int TW = ((W > 4) ? W : 4) + 1;

    logic [TW-1:0] taken;

    always_comb begin
        grant  = '0;
        reject = '0;
        taken  = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (taken < TW'(limit)) begin
                    grant[i] = 1'b1;
                    taken    = taken + 1'b1;
                end else begin
                    reject[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Lot occupancy register with per-lane entry/exit arbitration and status flags.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 99,
    parameter int N_ENTRY     = 2,
    parameter int N_EXIT      = 2,
    parameter int NEAR_MARGIN = 5,
    parameter int CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_ENTRY-1:0] entering,
    input  logic [N_EXIT-1:0]  exiting,
    input  logic               close_lot,
    input  logic               load_en,
    input  logic [CNT_W-1:0]   load_val,
    output logic [CNT_W-1:0]   count,
    output logic [N_ENTRY-1:0] grant_entry,
    output logic [N_ENTRY-1:0] reject_entry,
    output logic [N_EXIT-1:0]  grant_exit,
    output logic [N_EXIT-1:0]  reject_exit,
    output logic               full,
    output logic               empty,
    output logic               near_full,
    output logic [1:0]         lot_state
);

    localparam logic [CNT_W:0] CAP_X = (CNT_W + 1)'(CAPACITY);
    localparam logic [CNT_W:0] NEAR_TH = (CAPACITY > NEAR_MARGIN)
        ? (CNT_W + 1)'(CAPACITY - NEAR_MARGIN) : '0;
    localparam logic NEAR_RST = (CAPACITY <= NEAR_MARGIN);

    logic [CNT_W-1:0]   count_q, count_d;
    lot_state_t         state_q, state_d;
    logic [N_ENTRY-1:0] ge_q, ge_d, re_q, re_d;
    logic [N_EXIT-1:0]  gx_q, gx_d, rx_q, rx_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               near_q, near_d;

    logic [N_EXIT-1:0]  ex_gnt, ex_rej;
    logic [N_ENTRY-1:0] en_gnt, en_rej;
    logic [CNT_W:0]     ex_g, en_g, left, avail_x, sum;
    logic [CNT_W-1:0]   en_limit;

    lane_grant_arbiter #(.N(N_EXIT), .W(CNT_W)) u_exit_arb (
        .req    (exiting),
        .limit  (count_q),
        .grant  (ex_gnt),
        .reject (ex_rej)
    );

    // Entries see the space freed by this cycle's exits.
    always_comb begin
        ex_g     = (CNT_W + 1)'(popcount(8'(ex_gnt)));
        left     = {1'b0, count_q} - ex_g;
        avail_x  = CAP_X - left;
        en_limit = CNT_W'(avail_x);
        if (close_lot || state_q == S_CLOSED) begin
            en_limit = '0;
        end
    end

    lane_grant_arbiter #(.N(N_ENTRY), .W(CNT_W)) u_entry_arb (
        .req    (entering),
        .limit  (en_limit),
        .grant  (en_gnt),
        .reject (en_rej)
    );

    always_comb begin
        en_g    = (CNT_W + 1)'(popcount(8'(en_gnt)));
        sum     = left + en_g;
        count_d = CNT_W'(sum);
        ge_d    = en_gnt;
        re_d    = en_rej;
        gx_d    = ex_gnt;
        rx_d    = ex_rej;
        if (load_en) begin
            count_d = CNT_W'(clamp_cap(32'(load_val), 32'(CAPACITY)));
            ge_d    = '0;
            re_d    = entering;
            gx_d    = '0;
            rx_d    = exiting;
        end
        full_d  = ({1'b0, count_d} == CAP_X);
        empty_d = (count_d == '0);
        near_d  = ({1'b0, count_d} >= NEAR_TH);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OPEN: begin
                if (close_lot)   state_d = S_CLOSED;
                else if (full_d) state_d = S_FULL;
            end
            S_FULL: begin
                if (close_lot)    state_d = S_CLOSED;
                else if (!full_d) state_d = S_OPEN;
            end
            S_CLOSED: begin
                if (!close_lot) state_d = full_d ? S_FULL : S_OPEN;
            end
            default: state_d = S_OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            state_q <= S_OPEN;
            ge_q    <= '0;
            re_q    <= '0;
            gx_q    <= '0;
            rx_q    <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            near_q  <= NEAR_RST;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            ge_q    <= ge_d;
            re_q    <= re_d;
            gx_q    <= gx_d;
            rx_q    <= rx_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            near_q  <= near_d;
        end
    end

    assign count        = count_q;
    assign grant_entry  = ge_q;
    assign reject_entry = re_q;
    assign grant_exit   = gx_q;
    assign reject_exit  = rx_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign near_full    = near_q;
    assign lot_state    = state_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl with a small lot (capacity 4).
module tb_parking_occupancy_ctrl;

    localparam int CAP    = 4;
    localparam int NE     = 2;
    localparam int NX     = 2;
    localparam int MARGIN = 1;
    localparam int W      = 3;

    localparam int ST_OPEN   = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_CLOSED = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NE-1:0] entering;
    logic [NX-1:0] exiting;
    logic          close_lot;
    logic          load_en;
    logic [W-1:0]  load_val;
    logic [W-1:0]  count;
    logic [NE-1:0] grant_entry, reject_entry;
    logic [NX-1:0] grant_exit, reject_exit;
    logic          full, empty, near_full;
    logic [1:0]    lot_state;

    parking_occupancy_ctrl #(
        .CAPACITY(CAP), .N_ENTRY(NE), .N_EXIT(NX), .NEAR_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .reset(reset),
        .entering(entering), .exiting(exiting),
        .close_lot(close_lot), .load_en(load_en), .load_val(load_val),
        .count(count),
        .grant_entry(grant_entry), .reject_entry(reject_entry),
        .grant_exit(grant_exit), .reject_exit(reject_exit),
        .full(full), .empty(empty), .near_full(near_full),
        .lot_state(lot_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        int ge, re, gx, rx;
        int fl, em, nf, st;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_count = 0;
    int   m_state = ST_OPEN;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [1:0] en, input logic [1:0] ex,
                        input logic cl, input logic ld, input logic [2:0] lv);
        exp_t e;
        int exg, eng, avail;
        @(negedge clk);
        entering  = en;
        exiting   = ex;
        close_lot = cl;
        load_en   = ld;
        load_val  = lv;
        e.ge = 0; e.re = 0; e.gx = 0; e.rx = 0;
        if (ld) begin
            m_count = (int'(lv) > CAP) ? CAP : int'(lv);
            e.re = int'(en);
            e.rx = int'(ex);
        end else begin
            exg = 0;
            for (int i = 0; i < NX; i++) begin
                if (ex[i]) begin
                    if (exg < m_count) begin
                        e.gx |= (1 << i);
                        exg++;
                    end else begin
                        e.rx |= (1 << i);
                    end
                end
            end
            avail = CAP - (m_count - exg);
            if (cl || m_state == ST_CLOSED) avail = 0;
            eng = 0;
            for (int i = 0; i < NE; i++) begin
                if (en[i]) begin
                    if (eng < avail) begin
                        e.ge |= (1 << i);
                        eng++;
                    end else begin
                        e.re |= (1 << i);
                    end
                end
            end
            m_count = m_count - exg + eng;
        end
        if (cl) m_state = ST_CLOSED;
        else    m_state = (m_count == CAP) ? ST_FULL : ST_OPEN;
        e.cnt = m_count;
        e.fl  = (m_count == CAP) ? 1 : 0;
        e.em  = (m_count == 0) ? 1 : 0;
        e.nf  = (m_count >= CAP - MARGIN) ? 1 : 0;
        e.st  = m_state;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                chk("count",        int'(count),        e.cnt);
                chk("grant_entry",  int'(grant_entry),  e.ge);
                chk("reject_entry", int'(reject_entry), e.re);
                chk("grant_exit",   int'(grant_exit),   e.gx);
                chk("reject_exit",  int'(reject_exit),  e.rx);
                chk("full",         int'(full),         e.fl);
                chk("empty",        int'(empty),        e.em);
                chk("near_full",    int'(near_full),    e.nf);
                chk("lot_state",    int'(lot_state),    e.st);
            end
        end
    end

    task automatic chk_cleared(input string tag);
        chk({tag, "_count"},     int'(count),        0);
        chk({tag, "_gnt_entry"}, int'(grant_entry),  0);
        chk({tag, "_rej_entry"}, int'(reject_entry), 0);
        chk({tag, "_gnt_exit"},  int'(grant_exit),   0);
        chk({tag, "_rej_exit"},  int'(reject_exit),  0);
        chk({tag, "_empty"},     int'(empty),        1);
        chk({tag, "_full"},      int'(full),         0);
        chk({tag, "_near"},      int'(near_full),    (CAP <= MARGIN) ? 1 : 0);
        chk({tag, "_state"},     int'(lot_state),    ST_OPEN);
    endtask

    initial begin : driver
        int budget;
        reset     = 1'b1;
        entering  = '0;
        exiting   = '0;
        close_lot = 1'b0;
        load_en   = 1'b0;
        load_val  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_cleared("reset");
        @(negedge clk);
        reset = 1'b0;

        // fill, simultaneous in/out at full, partial grants, underflow
        step(2'b11, 2'b00, 0, 0, 0);
        step(2'b11, 2'b00, 0, 0, 0);
        step(2'b01, 2'b01, 0, 0, 0);
        step(2'b00, 2'b01, 0, 0, 0);
        step(2'b11, 2'b00, 0, 0, 0);
        step(2'b00, 2'b11, 0, 0, 0);
        step(2'b00, 2'b01, 0, 0, 0);
        step(2'b00, 2'b11, 0, 0, 0);
        step(2'b00, 2'b11, 0, 0, 0);
        // close mode and release
        step(2'b11, 2'b00, 0, 0, 0);
        step(2'b11, 2'b01, 1, 0, 0);
        step(2'b01, 2'b00, 0, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0);
        // recount load with clamp
        step(2'b01, 2'b00, 0, 1, 3'd7);
        step(2'b00, 2'b01, 0, 0, 0);

        // asynchronous reset mid-cycle with requests pending
        step(2'b11, 2'b01, 0, 0, 0);
        #2;
        reset = 1'b1;
        q.delete();
        m_count = 0;
        m_state = ST_OPEN;
        #1;
        chk_cleared("async_rst");
        @(negedge clk);
        entering = '0;
        exiting  = '0;
        @(negedge clk);
        reset = 1'b0;
        step(2'b00, 2'b00, 0, 0, 0);
        step(2'b00, 2'b00, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                 3'($urandom_range(0, 7)));
        end
        @(negedge clk);
        entering  = '0;
        exiting   = '0;
        close_lot = 1'b0;
        load_en   = 1'b0;

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
